// File: rtl/reg_file.sv
// Single-port synchronous register file with a registered read port and a synchronous active-low reset.
// Optional build macro REG_FILE_WRITE_BYPASS_EN forwards write data to the read port on simultaneous access.
module reg_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_DEPTH = 16,
    parameter int ADDRESS_WIDTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_write_enable,
    input  logic                     i_read_enable,
    input  logic [DATA_WIDTH-1:0]    i_write_data,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0]    o_read_data
);

    logic [DATA_WIDTH-1:0] mem_q [REGISTER_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [REGISTER_DEPTH];
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [DATA_WIDTH-1:0] read_data_d;
    logic [DATA_WIDTH-1:0] entry_sel;
    logic [REGISTER_DEPTH-1:0] addr_hit;
    logic                  addr_in_range;

    // One-hot address decode; an address past the last entry hits nothing.
    generate
        for (genvar gi = 0; gi < REGISTER_DEPTH; gi++) begin : g_decode
            assign addr_hit[gi] = (32'(i_address) == gi);
        end
    endgenerate

    assign addr_in_range = |addr_hit;

    always_comb begin
        entry_sel = '0;
        for (int i = 0; i < REGISTER_DEPTH; i++) begin
            if (addr_hit[i]) begin
                entry_sel = mem_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < REGISTER_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (i_write_enable && addr_hit[i]) begin
                mem_d[i] = i_write_data;
            end
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        if (i_read_enable) begin
            if (!addr_in_range) begin
                read_data_d = '0;
            end else begin
`ifdef REG_FILE_WRITE_BYPASS_EN
                read_data_d = i_write_enable ? i_write_data : entry_sel;
`else
                // entry_sel comes from mem_q, so a same-cycle write is not visible yet.
                read_data_d = entry_sel;
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REGISTER_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            read_data_q <= '0;
        end else begin
            for (int i = 0; i < REGISTER_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            read_data_q <= read_data_d;
        end
    end

    assign o_read_data = read_data_q;

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: vector table plus hand-written sequences, checked through an expected-value queue.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [3:0]  addr;
    logic [31:0] rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [16];

    typedef struct {
        logic        rst_n;
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    reg_file #(
        .DATA_WIDTH(32),
        .REGISTER_DEPTH(16),
        .ADDRESS_WIDTH(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_write_enable(we),
        .i_read_enable(re),
        .i_write_data(wdata),
        .i_address(addr),
        .o_read_data(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic s_rst_n, input logic s_we, input logic s_re,
                        input logic [3:0] s_addr, input logic [31:0] s_wdata,
                        input logic s_chk, input logic [31:0] s_exp, input string name);
        logic [31:0] want;
        @(negedge clk);
        rst_n = s_rst_n;
        we    = s_we;
        re    = s_re;
        addr  = s_addr;
        wdata = s_wdata;
        if (s_chk) exp_q.push_back(s_exp);
        if (!s_rst_n) begin
            for (int i = 0; i < 16; i++) model[i] = 32'h0;
        end else if (s_we) begin
            model[s_addr] = s_wdata;
        end
        @(posedge clk);
        #1;
        if (s_chk) begin
            want = exp_q.pop_front();
            total_cnt++;
            if (rdata !== want) begin
                $display("FAIL %s: addr=%0d got=0x%08h expected=0x%08h", name, s_addr, rdata, want);
            end else begin
                pass_cnt++;
                $display("ok   %s: addr=%0d data=0x%08h", name, s_addr, rdata);
            end
        end
    endtask

    vec_t vecs [10];
    logic [31:0] simul_exp;
    logic [31:0] e;

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // Reset clear: make the read register non-zero, then reset and confirm it clears.
        step(0, 0, 0, 4'd0,  32'h0,        1, 32'h0,        "reset_state");
        step(1, 1, 0, 4'd12, 32'h0000000F, 0, 32'h0,        "wr12");
        step(1, 0, 1, 4'd12, 32'h0,        1, 32'h0000000F, "pre_reset_read12");
        step(0, 0, 0, 4'd0,  32'h0,        1, 32'h0,        "reset_clears_rdata");
        step(1, 0, 1, 4'd12, 32'h0,        1, 32'h0,        "reset_clears_entry12");

        vecs[0] = '{1, 1, 0, 4'd12, 32'h0000000F, 0, 32'h0};
        vecs[1] = '{1, 1, 0, 4'd12, 32'h0000000F, 0, 32'h0};
        vecs[2] = '{1, 0, 1, 4'd12, 32'h0,        1, 32'h0000000F};
        vecs[3] = '{1, 0, 0, 4'd12, 32'h0,        1, 32'h0000000F};
        vecs[4] = '{1, 0, 1, 4'd15, 32'h0,        1, 32'h0};
        vecs[5] = '{1, 0, 0, 4'd15, 32'h0,        1, 32'h0};
        vecs[6] = '{1, 1, 0, 4'd7,  32'h00000001, 0, 32'h0};
        vecs[7] = '{1, 1, 0, 4'd7,  32'hCAFEF00D, 0, 32'h0};
        vecs[8] = '{1, 0, 1, 4'd7,  32'h0,        1, 32'hCAFEF00D};
        vecs[9] = '{1, 1, 0, 4'd9,  32'h55555555, 1, 32'hCAFEF00D};
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst_n, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                 vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Full sweep, then a single overwrite that must disturb no other entry.
        for (int a = 0; a < 16; a++) begin
            step(1, 1, 0, 4'(a), 32'(a) * 32'h11111111, 0, 32'h0, "sweep_wr");
        end
        for (int a = 0; a < 16; a++) begin
            step(1, 0, 1, 4'(a), 32'h0, 1, 32'(a) * 32'h11111111, "sweep_rd");
        end
        step(1, 1, 0, 4'd3, 32'hDEADBEEF, 0, 32'h0, "overwrite3");
        for (int a = 0; a < 16; a++) begin
            e = (a == 3) ? 32'hDEADBEEF : 32'(a) * 32'h11111111;
            step(1, 0, 1, 4'(a), 32'h0, 1, e, "after_overwrite");
        end

        // Simultaneous read and write on the shared address.
        step(1, 1, 0, 4'd5, 32'hA5A5A5A5, 0, 32'h0, "wr5");
`ifdef REG_FILE_WRITE_BYPASS_EN
        simul_exp = 32'h12345678;
`else
        simul_exp = 32'hA5A5A5A5;
`endif
        step(1, 1, 1, 4'd5, 32'h12345678, 1, simul_exp,    "simul_rw5");
        step(1, 0, 1, 4'd5, 32'h0,        1, 32'h12345678, "read5_after_rw");

        // Reset overrides a write and a read in the same cycle.
        step(0, 1, 1, 4'd2, 32'hFFFFFFFF, 1, 32'h0, "reset_with_write2");
        step(1, 0, 1, 4'd2, 32'h0,        1, 32'h0, "read2_after_reset");
        step(1, 0, 1, 4'd5, 32'h0,        1, 32'h0, "read5_after_reset");
        e = model[3];
        step(1, 0, 1, 4'd3, 32'h0,        1, e,     "read3_model");

        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_drain: leftover=%0d expected=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
